// File: rtl/eq2_selftest.sv
// Self-checking sweep stage for the 2-bit equality comparator eq2: drives all 16 operand pairs,
// samples aeqb after SETTLE cycles and reports pass/err_cnt/first failure. Optional: EQ2_SELFTEST_STOP_ON_ERR_EN.
module eq2_selftest #(
   parameter int SETTLE = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic [1:0] a,
   output logic [1:0] b,
   input  logic       aeqb,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [4:0] err_cnt,
   output logic [1:0] fail_a,
   output logic [1:0] fail_b,
   output logic       fail_vld
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETTLE = 2'd1;
   localparam logic [1:0] S_CHECK  = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

`ifdef EQ2_SELFTEST_STOP_ON_ERR_EN
   localparam logic STOP_EN = 1'b1;
`else
   localparam logic STOP_EN = 1'b0;
`endif

   logic [1:0] state_q, state_d;
   logic [3:0] idx_q, idx_d;
   logic [3:0] cnt_q, cnt_d;
   logic [4:0] err_q, err_d;
   logic [1:0] fail_a_q, fail_a_d;
   logic [1:0] fail_b_q, fail_b_d;
   logic       fail_vld_q, fail_vld_d;
   logic       mismatch;

   // Operands come straight from the index flops, so they only move when idx does.
   assign a        = idx_q[3:2];
   assign b        = idx_q[1:0];
   assign mismatch = aeqb != (idx_q[3:2] == idx_q[1:0]);

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      err_d      = err_q;
      fail_a_d   = fail_a_q;
      fail_b_d   = fail_b_q;
      fail_vld_d = fail_vld_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               idx_d      = 4'd0;
               cnt_d      = CNT_INIT;
               err_d      = 5'd0;
               fail_a_d   = 2'd0;
               fail_b_d   = 2'd0;
               fail_vld_d = 1'b0;
               state_d    = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
            else               state_d = S_CHECK;
         end
         S_CHECK: begin
            if (mismatch) begin
               err_d = err_q + 5'd1;
               if (!fail_vld_q) begin
                  fail_a_d   = idx_q[3:2];
                  fail_b_d   = idx_q[1:0];
                  fail_vld_d = 1'b1;
               end
            end
            if ((STOP_EN && mismatch) || idx_q == 4'd15) begin
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q + 4'd1;
               cnt_d   = CNT_INIT;
               state_d = S_SETTLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         idx_q      <= 4'd0;
         cnt_q      <= 4'd0;
         err_q      <= 5'd0;
         fail_a_q   <= 2'd0;
         fail_b_q   <= 2'd0;
         fail_vld_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
         fail_a_q   <= fail_a_d;
         fail_b_q   <= fail_b_d;
         fail_vld_q <= fail_vld_d;
      end
   end

   assign busy     = (state_q == S_SETTLE) || (state_q == S_CHECK);
   assign done     = (state_q == S_DONE);
   assign pass     = done && (err_q == 5'd0);
   assign err_cnt  = err_q;
   assign fail_a   = fail_a_q;
   assign fail_b   = fail_b_q;
   assign fail_vld = fail_vld_q;

endmodule

// File: tb/tb_eq2_selftest.sv
// Directed bench for eq2_selftest: a correct comparator model and stuck-at faults on aeqb,
// restart/ignore behaviour, asynchronous reset mid-sweep, and a SETTLE=1 instance.
module tb_eq2_selftest;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [1:0] a, b;
   logic       aeqb;
   logic       busy, done, pass, fail_vld;
   logic [4:0] err_cnt;
   logic [1:0] fail_a, fail_b;

   logic       start1;
   logic [1:0] a1, b1;
   logic       aeqb1;
   logic       busy1, done1, pass1, fail_vld1;
   logic [4:0] err_cnt1;
   logic [1:0] fail_a1, fail_b1;

   int mode = 0;  // 0: correct eq2, 1: aeqb stuck at 0, 2: aeqb stuck at 1
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign aeqb  = (mode == 0) ? (a == b) : (mode == 2);
   assign aeqb1 = (a1 == b1);

   eq2_selftest #(.SETTLE(4)) dut (
      .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .aeqb(aeqb),
      .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
      .fail_a(fail_a), .fail_b(fail_b), .fail_vld(fail_vld)
   );

   eq2_selftest #(.SETTLE(1)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .a(a1), .b(b1), .aeqb(aeqb1),
      .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err_cnt1),
      .fail_a(fail_a1), .fail_b(fail_b1), .fail_vld(fail_vld1)
   );

   typedef struct {
      int         mode;
      int         exp_cyc;
      int         exp_err;
      logic       exp_pass;
      logic       exp_fvld;
      logic [1:0] exp_fa;
      logic [1:0] exp_fb;
      bit         restart30;
   } vec_t;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic run_sweep(input vec_t v);
      int cyc;
      int opbad;
      int last;
      int exp_idx;
      logic [3:0] ab;
      @(negedge clk);
      mode  = v.mode;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      chk("start_busy", int'(busy), 1);
      chk("start_done", int'(done), 0);
      chk("start_err_clear", int'(err_cnt), 0);
      chk("start_fvld_clear", int'(fail_vld), 0);
      cyc   = 0;
      opbad = 0;
      last  = v.exp_cyc / 5 - 1;
      while (1) begin
         exp_idx = cyc / 5;
         if (exp_idx > last) exp_idx = last;
         ab = {a, b};
         if (ab != exp_idx[3:0]) opbad++;
         if (pass && !done) opbad++;
         if (done || cyc >= 200) break;
         start = (v.restart30 && cyc == 29);
         @(posedge clk);
         #1 cyc++;
      end
      start = 1'b0;
      chk("done_cycle", cyc, v.exp_cyc);
      chk("operand_seq_bad", opbad, 0);
      chk("done_busy", int'(busy), 0);
      chk("err_cnt", int'(err_cnt), v.exp_err);
      chk("pass", int'(pass), int'(v.exp_pass));
      chk("fail_vld", int'(fail_vld), int'(v.exp_fvld));
      chk("fail_a", int'(fail_a), int'(v.exp_fa));
      chk("fail_b", int'(fail_b), int'(v.exp_fb));
   endtask

   vec_t tbl[5];
   vec_t good;

   initial begin
      int cyc1;
      good = '{0, 80, 0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0};
      tbl[0] = good;
`ifdef EQ2_SELFTEST_STOP_ON_ERR_EN
      tbl[1] = '{1, 5, 1, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0};
      tbl[2] = '{2, 10, 1, 1'b0, 1'b1, 2'd0, 2'd1, 1'b0};
`else
      tbl[1] = '{1, 80, 4, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0};
      tbl[2] = '{2, 80, 12, 1'b0, 1'b1, 2'd0, 2'd1, 1'b0};
`endif
      tbl[3] = tbl[1];  // restart from DONE must clear and reproduce
      tbl[4] = '{0, 80, 0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1};

      reset  = 1'b1;
      start  = 1'b0;
      start1 = 1'b0;
      #1;
      chk("reset_outputs", int'({a, b, busy, done, pass, err_cnt, fail_a, fail_b, fail_vld}), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 5; i++) run_sweep(tbl[i]);

      // Asynchronous reset partway through a sweep
      @(negedge clk);
      mode  = 1;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (37) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("midsweep_reset_outputs",
          int'({a, b, busy, done, pass, err_cnt, fail_a, fail_b, fail_vld}), 0);
      @(posedge clk);
      #1 chk("reset_hold_idle", int'({busy, done}), 0);
      @(negedge clk);
      reset = 1'b0;
      run_sweep(good);

      // SETTLE=1 instance
      @(negedge clk);
      start1 = 1'b1;
      @(posedge clk);
      #1 start1 = 1'b0;
      cyc1 = 0;
      while (!done1 && cyc1 < 200) begin
         @(posedge clk);
         #1 cyc1++;
      end
      chk("settle1_done_cycle", cyc1, 32);
      chk("settle1_pass", int'(pass1), 1);
      chk("settle1_err_cnt", int'(err_cnt1), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
